// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// with write-before-read bypass, and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int NRD      = 2,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  output logic                any_busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_we0_eff;
  logic             w_we1_eff;
  logic             w_alloc_eff;

  assign w_we0_eff   = we0      & ~((ZERO_REG != 0) && (wa0 == '0));
  assign w_we1_eff   = we1      & ~((ZERO_REG != 0) && (wa1 == '0));
  assign w_alloc_eff = alloc_en & ~((ZERO_REG != 0) && (alloc_addr == '0));

  // Writebacks clear first, then an allocation sets, so a new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we0_eff) w_busy_nxt[wa0] = 1'b0;
    if (w_we1_eff) w_busy_nxt[wa1] = 1'b0;
    if (w_alloc_eff) w_busy_nxt[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
    end else begin
      if (w_we0_eff) r_regs[wa0] <= wd0;
      if (w_we1_eff) r_regs[wa1] <= wd1;
      r_busy <= w_busy_nxt;
    end
  end

  // Outputs are forced to zero while reset is held, so in-flight write bypass cannot leak.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0] v_a;
      logic          v_hit0;
      logic          v_hit1;
      v_a    = ra[k*AW +: AW];
      v_hit0 = w_we0_eff && (wa0 == v_a);
      v_hit1 = w_we1_eff && (wa1 == v_a);
      if (rst && !((ZERO_REG != 0) && (v_a == '0))) begin
        if (v_hit1)      rd[k*XLEN +: XLEN] = wd1;
        else if (v_hit0) rd[k*XLEN +: XLEN] = wd0;
        else             rd[k*XLEN +: XLEN] = r_regs[v_a];
        rd_busy[k] = r_busy[v_a] & ~(v_hit0 | v_hit1);
      end
    end
  end

  assign any_busy = |r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus
// and are compared against an array-based model of the architectural state.
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we0, we1, alloc_en;
  logic [AW-1:0]   wa0, wa1, alloc_addr, ra0, ra1;
  logic [XLEN-1:0] wd0, wd1;
  logic [NRD*XLEN-1:0] rd_z1, rd_z0;
  logic [NRD-1:0]  rdb_z1, rdb_z0;
  logic            ab_z1, ab_z0;

  int checks = 0;
  int failures = 0;

  logic [XLEN-1:0] m_mem  [2][NREGS];
  bit              m_busy [2][NREGS];

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .NRD(NRD)) u_z1 (
    .clk(clk), .rst(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ra({ra1, ra0}),
    .rd(rd_z1), .rd_busy(rdb_z1), .any_busy(ab_z1));

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0), .NRD(NRD)) u_z0 (
    .clk(clk), .rst(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ra({ra1, ra0}),
    .rd(rd_z0), .rd_busy(rdb_z0), .any_busy(ab_z0));

  function automatic bit hw_zero(int z, logic [AW-1:0] a);
    return (z == 1) && (a == 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int z, logic [AW-1:0] a);
    if (!rst_n || hw_zero(z, a)) return '0;
    if (we1 && !hw_zero(z, wa1) && wa1 == a) return wd1;
    if (we0 && !hw_zero(z, wa0) && wa0 == a) return wd0;
    return m_mem[z][a];
  endfunction

  function automatic logic exp_busy(int z, logic [AW-1:0] a);
    if (!rst_n || hw_zero(z, a)) return 1'b0;
    if (we1 && !hw_zero(z, wa1) && wa1 == a) return 1'b0;
    if (we0 && !hw_zero(z, wa0) && wa0 == a) return 1'b0;
    return m_busy[z][a];
  endfunction

  function automatic logic exp_any(int z);
    logic r = 1'b0;
    for (int i = 0; i < NREGS; i++) r |= m_busy[z][i];
    return r;
  endfunction

  task automatic m_clear();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NREGS; i++) begin
        m_mem[z][i] = '0;
        m_busy[z][i] = 1'b0;
      end
  endtask

  task automatic m_edge();
    if (!rst_n) return;
    for (int z = 0; z < 2; z++) begin
      if (we0 && !hw_zero(z, wa0)) begin m_mem[z][wa0] = wd0; m_busy[z][wa0] = 1'b0; end
      if (we1 && !hw_zero(z, wa1)) begin m_mem[z][wa1] = wd1; m_busy[z][wa1] = 1'b0; end
      if (alloc_en && !hw_zero(z, alloc_addr)) m_busy[z][alloc_addr] = 1'b1;
    end
  endtask

  task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    for (int z = 0; z < 2; z++) begin
      for (int k = 0; k < NRD; k++) begin
        logic [AW-1:0] a;
        logic [XLEN-1:0] od;
        logic ob;
        a  = (k == 0) ? ra0 : ra1;
        od = (z == 1) ? rd_z1[k*XLEN +: XLEN] : rd_z0[k*XLEN +: XLEN];
        ob = (z == 1) ? rdb_z1[k] : rdb_z0[k];
        chk($sformatf("%s z%0d rd%0d a=%0d", tag, z, k, a), od, exp_rd(z, a));
        chk($sformatf("%s z%0d busy%0d a=%0d", tag, z, k, a), {31'b0, ob}, {31'b0, exp_busy(z, a)});
      end
      chk($sformatf("%s z%0d any_busy", tag, z), {31'b0, (z == 1) ? ab_z1 : ab_z0},
          {31'b0, rst_n & exp_any(z)});
    end
  endtask

  task automatic set(logic e0, logic [AW-1:0] a0, logic [XLEN-1:0] d0,
                     logic e1, logic [AW-1:0] a1, logic [XLEN-1:0] d1,
                     logic al, logic [AW-1:0] aa, logic [AW-1:0] r0, logic [AW-1:0] r1);
    we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    alloc_en = al; alloc_addr = aa; ra0 = r0; ra1 = r1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle(logic [AW-1:0] r0, logic [AW-1:0] r1);
    set(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    m_clear();
    #1 check("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release");
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    m_clear();
    idle(5, 0);
    @(negedge clk);
    check("reset");
    chk("reset any_busy", {31'b0, ab_z1}, 32'h0);
    rst_n = 1'b1;
    step();

    // Bypass on port 0, then read from storage.
    set(1, 3, 32'h11, 0, 0, 0, 0, 0, 3, 0);
    check("bypass");
    chk("bypass rd0", rd_z1[31:0], 32'h11);
    step();
    idle(3, 0);
    check("bypass_stored");
    chk("stored rd0", rd_z1[31:0], 32'h11);
    step();

    // Dual-write collision: port 1 wins.
    set(1, 9, 32'hAAAA0000, 1, 9, 32'h5555FFFF, 0, 0, 9, 9);
    check("collide");
    chk("collide rd1", rd_z1[63:32], 32'h5555FFFF);
    step();
    idle(9, 0);
    check("collide_stored");
    chk("collide stored", rd_z1[31:0], 32'h5555FFFF);
    step();

    // Scoreboard allocate / writeback.
    set(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    check("alloc_c0");
    step();
    idle(12, 0);
    check("alloc_c1");
    chk("alloc busy", {31'b0, rdb_z1[0]}, 32'h1);
    chk("alloc any", {31'b0, ab_z1}, 32'h1);
    step();
    check("alloc_c2");
    step();
    set(1, 12, 32'h42, 0, 0, 0, 0, 0, 12, 0);
    check("wb_c3");
    chk("wb rd", rd_z1[31:0], 32'h42);
    chk("wb busy", {31'b0, rdb_z1[0]}, 32'h0);
    step();
    idle(12, 0);
    check("wb_c4");
    chk("wb any", {31'b0, ab_z1}, 32'h0);
    step();

    // Alloc and write to the same register: alloc wins.
    set(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    step();
    set(0, 0, 0, 1, 4, 32'h1234, 1, 4, 4, 0);
    check("alloc_wr_same");
    step();
    idle(4, 0);
    check("alloc_wr_next");
    chk("alloc wins", {31'b0, rdb_z1[0]}, 32'h1);
    set(1, 4, 32'h77, 0, 0, 0, 0, 0, 4, 0);
    step();

    // Register 0 with both ZERO_REG settings.
    set(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    check("zero_wr");
    step();
    idle(0, 0);
    check("zero_after");
    chk("z1 x0", rd_z1[31:0], 32'h0);
    chk("z1 any", {31'b0, ab_z1}, 32'h0);
    chk("z0 x0", rd_z0[31:0], 32'hFFFFFFFF);
    set(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset asserted mid-cycle clears state immediately.
    set(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 7, 5, 7);
    step();
    idle(5, 7);
    check("pre_reset");
    chk("pre x5", rd_z1[31:0], 32'hDEADBEEF);
    pulse_reset();
    chk("post x5", rd_z1[31:0], 32'h0);
    step();

    for (int n = 0; n < 400; n++) begin
      set(1'($urandom_range(0, 1)), raddr(), $urandom(),
          1'($urandom_range(0, 1)), raddr(), $urandom(),
          1'($urandom_range(0, 2) == 0), raddr(), raddr(), raddr());
      check($sformatf("rand%0d", n));
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
